ram_port_arbiter: RTL and testbench

//  Shares one single-port RAM between two masters using stb/ack handshakes:
//  the instruction fetch port (ibus, read-only) and the load/store port (dbus, read/write).

---
 rtl/ram_arb_pkg.sv | 8 +
 rtl/ram_arb_pick.sv | 19 +
 rtl/ram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the RAM port arbiter (FSM states, grant encoding, timer sizing).
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
  function automatic int tmr_w(input int timeout);
    return $clog2(timeout);
  endfunction
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner select between ibus and dbus requests.
// RAM_ARB_RR_EN defined: round-robin on ties; undefined: dbus wins every tie.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic i_ibus_stb,
  input  logic i_dbus_stb,
  input  gnt_t i_last_gnt,
  output gnt_t o_gnt
);
`ifdef RAM_ARB_RR_EN
  assign o_gnt = (i_ibus_stb && i_dbus_stb) ? ((i_last_gnt == GNT_I) ? GNT_D : GNT_I)
                                            : (i_dbus_stb ? GNT_D : GNT_I);
`else
  logic w_unused;
  assign w_unused = i_ibus_stb | logic'(i_last_gnt);
  assign o_gnt    = i_dbus_stb ? GNT_D : GNT_I;
`endif
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between ibus (fetch) and dbus (load/store),
// one transaction in flight, with a watchdog abort. Macro RAM_ARB_RR_EN enables round-robin.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ibus_stb_i,
  input  logic [ADDR_W-1:0] ibus_addr_i,
  output logic [DATA_W-1:0] ibus_data_o,
  output logic              ibus_ack_o,
  output logic              ibus_err_o,
  input  logic              dbus_stb_i,
  input  logic              dbus_we_i,
  input  logic [ADDR_W-1:0] dbus_addr_i,
  input  logic [DATA_W-1:0] dbus_data_i,
  output logic [DATA_W-1:0] dbus_data_o,
  output logic              dbus_ack_o,
  output logic              dbus_err_o,
  output logic              ram_stb_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_ack_i
);
  localparam int TW = tmr_w(TIMEOUT);

  state_t            r_state, w_state_nx;
  gnt_t              r_gnt, w_pick, w_last;
  logic [TW-1:0]     r_tmr;
  logic              w_req, w_tout, w_done;
  logic              r_ram_stb, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_data, r_ibus_data, r_dbus_data;
  logic              r_ibus_ack, r_ibus_err, r_dbus_ack, r_dbus_err;

  assign w_req  = ibus_stb_i | dbus_stb_i;
  assign w_tout = r_tmr == TW'(TIMEOUT - 1);
  assign w_done = ram_ack_i | w_tout;

  ram_arb_pick u_pick (
    .i_ibus_stb (ibus_stb_i),
    .i_dbus_stb (dbus_stb_i),
    .i_last_gnt (w_last),
    .o_gnt      (w_pick)
  );

`ifdef RAM_ARB_RR_EN
  gnt_t r_last;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_last <= GNT_I;
    else if (r_state == RESP) r_last <= r_gnt;
  assign w_last = r_last;
`else
  assign w_last = GNT_I;
`endif

  always_comb begin
    w_state_nx = (r_state == IDLE)  ? (w_req  ? ISSUE : IDLE)
               : (r_state == ISSUE) ? (w_done ? RESP  : ISSUE)
               : IDLE;
  end

  // ack registers are set on the ISSUE->RESP edge so they are high for the RESP cycle only
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= GNT_I;
      r_tmr       <= '0;
      r_ram_stb   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_data  <= '0;
      r_ibus_data <= '0;
      r_ibus_ack  <= 1'b0;
      r_ibus_err  <= 1'b0;
      r_dbus_data <= '0;
      r_dbus_ack  <= 1'b0;
      r_dbus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_ibus_ack <= 1'b0;
      r_dbus_ack <= 1'b0;
      if (r_state == IDLE && w_req) begin
        r_gnt      <= w_pick;
        r_ram_stb  <= 1'b1;
        r_ram_we   <= (w_pick == GNT_D) && dbus_we_i;
        r_ram_addr <= (w_pick == GNT_D) ? dbus_addr_i : ibus_addr_i;
        r_ram_data <= (w_pick == GNT_D) ? dbus_data_i : '0;
        r_tmr      <= '0;
      end
      if (r_state == ISSUE) begin
        r_tmr <= r_tmr + 1'b1;
        if (w_done) begin
          r_ram_stb <= 1'b0;
          if (r_gnt == GNT_D) begin
            r_dbus_ack  <= 1'b1;
            r_dbus_err  <= !ram_ack_i;
            r_dbus_data <= ram_ack_i ? ram_data_i : '0;
          end else begin
            r_ibus_ack  <= 1'b1;
            r_ibus_err  <= !ram_ack_i;
            r_ibus_data <= ram_ack_i ? ram_data_i : '0;
          end
        end
      end
    end
  end

  assign ibus_data_o = r_ibus_data;
  assign ibus_ack_o  = r_ibus_ack;
  assign ibus_err_o  = r_ibus_err;
  assign dbus_data_o = r_dbus_data;
  assign dbus_ack_o  = r_dbus_ack;
  assign dbus_err_o  = r_dbus_err;
  assign ram_stb_o   = r_ram_stb;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_data_o  = r_ram_data;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized + directed bench with a RAM model and reference memory scoreboard.
module tb_ram_port_arbiter;
  localparam int TO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        ibus_stb_i = 1'b0;
  logic [15:0] ibus_addr_i = '0;
  logic [31:0] ibus_data_o;
  logic        ibus_ack_o, ibus_err_o;
  logic        dbus_stb_i = 1'b0;
  logic        dbus_we_i = 1'b0;
  logic [15:0] dbus_addr_i = '0;
  logic [31:0] dbus_data_i = '0;
  logic [31:0] dbus_data_o;
  logic        dbus_ack_o, dbus_err_o;
  logic        ram_stb_o, ram_we_o;
  logic [15:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;
  logic        ram_ack_i = 1'b0;

  always #5 sys_clk = ~sys_clk;

  ram_port_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .ibus_stb_i(ibus_stb_i), .ibus_addr_i(ibus_addr_i), .ibus_data_o(ibus_data_o),
    .ibus_ack_o(ibus_ack_o), .ibus_err_o(ibus_err_o),
    .dbus_stb_i(dbus_stb_i), .dbus_we_i(dbus_we_i), .dbus_addr_i(dbus_addr_i),
    .dbus_data_i(dbus_data_i), .dbus_data_o(dbus_data_o), .dbus_ack_o(dbus_ack_o),
    .dbus_err_o(dbus_err_o),
    .ram_stb_o(ram_stb_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_ack_i(ram_ack_i)
  );

  int          n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          ram_delay = -1, ram_wait = 0, stb_len = 0, last_lat = 0;
  bit          rand_dly = 0, ram_acked = 0, in_flight = 0, exp_win = 0, last_win = 0;
  bit          prev_stb = 0, hold = 0, pend_i = 0, pend_d = 0;
  logic [15:0] iss_addr;
  logic        iss_we;
  logic [31:0] iss_data;
  int          req_cyc_i = 0, req_cyc_d = 0, n_req_i = 0, n_req_d = 0, n_ack_i = 0, n_ack_d = 0;
  bit          gq [$];
  bit          exp_g [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_ibus"}, {ibus_data_o, ibus_ack_o, ibus_err_o}, 64'h0);
    chk({t, "_dbus"}, {dbus_data_o, dbus_ack_o, dbus_err_o}, 64'h0);
    chk({t, "_ram"}, {ram_stb_o, ram_we_o, ram_addr_o, ram_data_o}, 64'h0);
  endtask

  // Arbitration rule: lone requester wins; on a tie round-robin or dbus priority
  function automatic bit pick_win(input bit si, input bit sd);
    if (si && sd) begin
`ifdef RAM_ARB_RR_EN
      return !last_win;
`else
      return 1'b1;
`endif
    end
    return sd;
  endfunction

  task automatic req_i(input logic [15:0] a);
    ibus_stb_i = 1'b1; ibus_addr_i = a; pend_i = 1; n_req_i++; req_cyc_i = cyc;
  endtask

  task automatic req_d(input logic we, input logic [15:0] a, input logic [31:0] d);
    dbus_stb_i = 1'b1; dbus_we_i = we; dbus_addr_i = a; dbus_data_i = d;
    pend_d = 1; n_req_d++; req_cyc_d = cyc;
  endtask

  task automatic observe();
    bit w;
    logic [31:0] ed;
    if (ram_stb_o && !prev_stb) begin
      chk("grant_has_req", {63'h0, ibus_stb_i | dbus_stb_i}, 64'h1);
      w = pick_win(ibus_stb_i, dbus_stb_i);
      iss_addr = w ? dbus_addr_i : ibus_addr_i;
      iss_we   = w & dbus_we_i;
      iss_data = dbus_data_i;
      chk("grant_addr", ram_addr_o, iss_addr);
      chk("grant_we", ram_we_o, iss_we);
      if (iss_we) chk("grant_wdata", ram_data_o, iss_data);
      exp_win = w; in_flight = 1; gq.push_back(w);
      stb_len = 0; ram_acked = 0; ram_wait = 0;
      if (rand_dly) ram_delay = $urandom_range(0, 5);
    end else if (ram_stb_o) begin
      chk("ram_hold", {ram_we_o, ram_addr_o, iss_we ? ram_data_o : 32'h0},
                      {iss_we, iss_addr, iss_we ? iss_data : 32'h0});
    end
    if (ram_stb_o) stb_len++;
    if (ibus_ack_o || dbus_ack_o) begin
      chk("ack_owner", {dbus_ack_o, ibus_ack_o}, !in_flight ? 64'h0 : exp_win ? 64'h2 : 64'h1);
      if (in_flight) begin
        ed = !ram_acked ? 32'h0 : iss_we ? iss_data : ref_mem[iss_addr[7:0]];
        if (ram_acked && iss_we) ref_mem[iss_addr[7:0]] = iss_data;
        chk("stb_len", stb_len, ram_acked ? ram_delay + 1 : TO);
        if (exp_win) begin
          chk("dbus_err", dbus_err_o, !ram_acked);
          chk("dbus_data", dbus_data_o, ed);
          chk("dbus_pend", pend_d, 1);
          n_ack_d++; last_lat = cyc - req_cyc_d; pend_d = 0;
          if (hold && gq.size() < 4) req_d(dbus_we_i, dbus_addr_i, dbus_data_i);
          else dbus_stb_i = 1'b0;
        end else begin
          chk("ibus_err", ibus_err_o, !ram_acked);
          chk("ibus_data", ibus_data_o, ed);
          chk("ibus_pend", pend_i, 1);
          n_ack_i++; last_lat = cyc - req_cyc_i; pend_i = 0;
          if (hold && gq.size() < 4) req_i(ibus_addr_i);
          else ibus_stb_i = 1'b0;
        end
        last_win = exp_win; in_flight = 0;
      end
    end
    prev_stb = ram_stb_o;
  endtask

  // RAM model: acks after ram_delay ISSUE cycles (never when negative)
  task automatic ram_drive();
    ram_ack_i  = 1'b0;
    ram_data_i = $urandom;
    if (ram_stb_o) begin
      if (ram_delay >= 0 && ram_wait == ram_delay) begin
        ram_ack_i  = 1'b1;
        ram_data_i = ram_we_o ? ram_data_o : mem[ram_addr_o[7:0]];
        if (ram_we_o) mem[ram_addr_o[7:0]] = ram_data_o;
        ram_acked = 1;
      end
      ram_wait++;
    end else ram_wait = 0;
  endtask

  task automatic step();
    @(posedge sys_clk); #1;
    cyc++;
    observe();
    ram_drive();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((pend_i || pend_d) && n < 300) begin step(); n++; end
    chk({tag, "_drain"}, {pend_i, pend_d}, 64'h0);
    step();
    chk({tag, "_pulse"}, {ibus_ack_o, dbus_ack_o}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[16] = 32'hCAFE0001; ref_mem[16] = 32'hCAFE0001;
`ifdef RAM_ARB_RR_EN
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    #3 sys_rst_n = 1'b0;
    #10 chk_zero("reset");
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // lone ibus read
    ram_delay = 1;
    req_i(16'h0010);
    wait_idle("t1");
    chk("t1_lat", last_lat, 3);
    chk("t1_data", ibus_data_o, 32'hCAFE0001);
    chk("t1_dbus_quiet", {dbus_data_o, dbus_ack_o, dbus_err_o}, 64'h0);

    // both requesters held for four grants
    hold = 1; gq.delete();
    ram_delay = 0;
    req_i(16'h0030);
    req_d(1'b0, 16'h0031, 32'h0);
    wait_idle("t3");
    hold = 0;
    chk("t3_count", {63'h0, gq.size() >= 4}, 64'h1);
    if (gq.size() >= 4)
      for (int k = 0; k < 4; k++) chk($sformatf("t3_gnt%0d", k), gq[k], exp_g[k]);

    // lone dbus write, then read it back through ibus
    ram_delay = 3;
    req_d(1'b1, 16'h0020, 32'h12345678);
    step();
    chk("t2_ram", {ram_stb_o, ram_we_o, ram_addr_o, ram_data_o}, {1'b1, 1'b1, 16'h0020, 32'h12345678});
    wait_idle("t2");
    chk("t2_lat", last_lat, 5);
    chk("t2_err", dbus_err_o, 0);
    ram_delay = 0;
    req_i(16'h0020);
    wait_idle("t2rb");
    chk("t2_rb_data", ibus_data_o, 32'h12345678);
    chk("t2_rb_lat", last_lat, 2);

    // RAM never acknowledges
    ram_delay = -1;
    req_d(1'b0, 16'h0005, 32'h0);
    wait_idle("t4");
    chk("t4_err", dbus_err_o, 1);
    chk("t4_data", dbus_data_o, 0);
    chk("t4_lat", last_lat, TO + 1);
    ram_delay = 2;
    req_d(1'b0, 16'h0005, 32'h0);
    wait_idle("t4b");
    chk("t4b_err", dbus_err_o, 0);
    chk("t4b_data", dbus_data_o, ref_mem[5]);

    // asynchronous reset in ISSUE
    ram_delay = -1;
    req_d(1'b1, 16'h0040, 32'hDEADBEEF);
    step(); step();
    chk("t5_issue", ram_stb_o, 1);
    #1 sys_rst_n = 1'b0;
    #1 chk_zero("t5_async");
    in_flight = 0; last_win = 0; prev_stb = 0;
    @(posedge sys_clk); #1;
    chk_zero("t5_held");
    sys_rst_n = 1'b1;
    ram_delay = 1;
    na = n_ack_d;
    wait_idle("t5");
    chk("t5_acks", n_ack_d - na, 1);
    chk("t5_mem", ref_mem[8'h40], 32'hDEADBEEF);

    // randomized traffic with random RAM delays
    rand_dly = 1;
    for (int c = 0; c < 1500; c++) begin
      if (!pend_i && $urandom_range(0, 2) == 0) req_i(16'($urandom_range(0, 15)));
      if (!pend_d && $urandom_range(0, 2) == 0)
        req_d(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), $urandom);
      step();
    end
    wait_idle("t6");
    rand_dly = 0;
    chk("t6_ibus_acks", n_ack_i, n_req_i);
    chk("t6_dbus_acks", n_ack_d, n_req_d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
